// File: rtl/alu_status.sv
// alu_status: processor status register (P) with a two-stage flag-update
// pipeline and a registered decimal (BCD) adjust of the ALU result.
//
// A flag-update request is captured on one enabled edge and applied on the
// next enabled edge, using the ALU results that are valid by then.
// Same-edge priority, highest first: p_load, then flag_op, then the pending
// apply. The priority is resolved per bit.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   reset_n    : asynchronous active-low reset
//   RDY        : clock enable for all state
//   upd_sel    : flag-update request
//                (001 NZ, 010 NZC, 011 NVZC, 100 BIT, other values: none)
//   op_bcd     : request wants a decimal adjust
//   op_sub     : request is a subtract
//   mem_b76    : memory operand bits 7:6, used by BIT
//   alu_*      : registered ALU results, valid one cycle after the request
//   flag_op    : immediate flag command (CLC/SEC/CLI/SEI/CLD/SED/CLV)
//   p_load     : load P from p_din (PLP/RTI)
//   p_din      : value loaded into P when p_load is high
//   P          : status register {N,V,1,1,D,I,Z,C}
//   adj_out    : registered, decimal-adjusted result
//   adj_valid  : one-cycle pulse; adj_out was updated on this edge
module alu_status #(
    parameter logic [7:0] P_RESET = 8'h34
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       RDY,
    input  logic [2:0] upd_sel,
    input  logic       op_bcd,
    input  logic       op_sub,
    input  logic [1:0] mem_b76,
    input  logic [7:0] alu_out,
    input  logic       alu_co,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       alu_n,
    input  logic       alu_hc,
    input  logic [2:0] flag_op,
    input  logic       p_load,
    input  logic [7:0] p_din,
    output logic [7:0] P,
    output logic [7:0] adj_out,
    output logic       adj_valid
);

    // Bit positions inside P
    localparam int B_C = 0;
    localparam int B_Z = 1;
    localparam int B_I = 2;
    localparam int B_D = 3;
    localparam int B_V = 6;
    localparam int B_N = 7;

    // Bits 5 and 4 always read as 1, so they are also forced in the reset value
    localparam logic [7:0] P_INIT = P_RESET | 8'h30;

    logic [7:0] p_reg, p_next;
    logic [7:0] adj_out_reg, adj_next;
    logic       adj_valid_reg;
    logic       pend_valid_reg;
    logic [2:0] pend_sel_reg;
    logic       pend_bcd_reg;
    logic       pend_sub_reg;
    logic [1:0] pend_b76_reg;

    logic       req_valid;
    assign req_valid = (upd_sel >= 3'b001) && (upd_sel <= 3'b100);

    // Decimal adjust: each nibble is corrected on its own. The sum wraps
    // modulo 16 and there is no carry into the next nibble. The low nibble
    // is steered by the half carry and the high nibble by the carry out.
    logic [1:0] nib_carry;
    assign nib_carry = {alu_co, alu_hc};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_nib
            logic [3:0] inc;
            always_comb begin
                inc = 4'h0;
                if (pend_bcd_reg) begin
                    if (pend_sub_reg)
                        inc = nib_carry[gi] ? 4'h0 : 4'hA;
                    else
                        inc = nib_carry[gi] ? 4'h6 : 4'h0;
                end
            end
            assign adj_next[gi*4 +: 4] = alu_out[gi*4 +: 4] + inc;
        end
    endgenerate

    // Layered per-bit priority: pending apply, then flag_op, then p_load on top
    always_comb begin
        p_next = p_reg;
        if (pend_valid_reg) begin
            case (pend_sel_reg)
                3'b001: begin
                    p_next[B_N] = alu_n;
                    p_next[B_Z] = alu_z;
                end
                3'b010: begin
                    p_next[B_N] = alu_n;
                    p_next[B_Z] = alu_z;
                    p_next[B_C] = alu_co;
                end
                3'b011: begin
                    p_next[B_N] = alu_n;
                    p_next[B_V] = alu_v;
                    p_next[B_Z] = alu_z;
                    p_next[B_C] = alu_co;
                end
                3'b100: begin
                    // BIT leaves C alone; Z still comes from the ALU
                    p_next[B_N] = pend_b76_reg[1];
                    p_next[B_V] = pend_b76_reg[0];
                    p_next[B_Z] = alu_z;
                end
                default: ;
            endcase
        end
        case (flag_op)
            3'b001: p_next[B_C] = 1'b0;
            3'b010: p_next[B_C] = 1'b1;
            3'b011: p_next[B_I] = 1'b0;
            3'b100: p_next[B_I] = 1'b1;
            3'b101: p_next[B_D] = 1'b0;
            3'b110: p_next[B_D] = 1'b1;
            3'b111: p_next[B_V] = 1'b0;
            default: ;
        endcase
        if (p_load)
            p_next = p_din;
        p_next[5:4] = 2'b11;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_reg          <= P_INIT;
            adj_out_reg    <= 8'h00;
            adj_valid_reg  <= 1'b0;
            pend_valid_reg <= 1'b0;
            pend_sel_reg   <= 3'b000;
            pend_bcd_reg   <= 1'b0;
            pend_sub_reg   <= 1'b0;
            pend_b76_reg   <= 2'b00;
        end else if (RDY) begin
            p_reg          <= p_next;
            // The pending request is consumed even when p_load masks its flags
            adj_valid_reg  <= pend_valid_reg;
            if (pend_valid_reg)
                adj_out_reg <= adj_next;
            pend_valid_reg <= req_valid;
            pend_sel_reg   <= upd_sel;
            pend_bcd_reg   <= op_bcd;
            pend_sub_reg   <= op_sub;
            pend_b76_reg   <= mem_b76;
        end else begin
            // adj_valid is a pulse that marks an apply edge only, so it
            // drops on a stalled edge
            adj_valid_reg  <= 1'b0;
        end
    end

    assign P         = p_reg;
    assign adj_out   = adj_out_reg;
    assign adj_valid = adj_valid_reg;

endmodule

// File: doc/alu_status.md
ALU_STATUS -- requirements
Module: alu_status

Interface
REQ-001 Parameter P_RESET, default 8'h34, value of P after reset; bits 5 and 4 read 1 regardless.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset is asynchronous and active-low.
REQ-004 RDY  input  1  clock enable for all state; 0 holds everything, including pending request.
REQ-005 upd_sel  input  3  flag-update request, presented in the same cycle as the ALU operation: 000 none, 001 NZ, 010 NZC, 011 NVZC, 100 BIT, 101-111 none.
REQ-006 op_bcd  input  1  decimal adjust requested with this request.
REQ-007 op_sub  input  1  request is subtract (selects adjust direction).
REQ-008 mem_b76  input  2  memory operand bits 7:6, for BIT.
REQ-009 alu_out, alu_co, alu_v, alu_z, alu_n, alu_hc  input  8,1,1,1,1,1  registered ALU results, valid the cycle after the request.
REQ-010 flag_op  input  3  immediate flag command: 000 none, 001 CLC, 010 SEC, 011 CLI, 100 SEI, 101 CLD, 110 SED, 111 CLV.
REQ-011 p_load, p_din  input  1,8  load P from stack/bus (PLP/RTI).
REQ-012 P  output  8  status register {N,V,1,1,D,I,Z,C}.
REQ-013 adj_out  output  8  registered, decimal-adjusted result.
REQ-014 adj_valid  output  1  one-cycle pulse, adj_out updated this cycle.

Function
REQ-015 Two-stage pipeline: on RDY edge k, capture pend_valid=(upd_sel in 001..100), pend_sel, pend_bcd, pend_sub, pend_b76; on RDY edge k+1, apply using current alu_* inputs.
REQ-016 Capture and apply occur on the same edge for back-to-back requests; one request per RDY cycle sustained, no bubbles.
REQ-017 Apply: NZ sets N=alu_n, Z=alu_z; NZC additionally C=alu_co; NVZC additionally V=alu_v; BIT sets Z=alu_z, N=pend_b76[1], V=pend_b76[0]; C untouched by BIT.
REQ-018 Z in decimal mode comes from alu_z (binary result), not from adj_out.
REQ-019 Adjust is nibble-wise, mod 16 per nibble, no carry between nibbles.
REQ-020 Add (pend_bcd=1, pend_sub=0): low +6 if alu_hc; high +6 if alu_co.
REQ-021 Subtract (pend_bcd=1, pend_sub=1): low +0xA if !alu_hc; high +0xA if !alu_co.
REQ-022 pend_bcd=0: adj_out=alu_out.
REQ-023 adj_out and adj_valid update only on apply edges; adj_valid=0 on all other edges, including RDY=1 edges without a pending request.
REQ-024 flag_op applies on the edge it is presented with RDY=1.
REQ-025 Priority per bit, same edge: p_load > flag_op > pending apply; non-conflicting bits from lower sources still apply.
REQ-026 p_load: P=p_din with bits 5,4 forced 1; overrides every flag for that edge; the pending request is still consumed (adj_out/adj_valid still produced).
REQ-027 RDY=0 between capture and apply: apply deferred to first RDY=1 edge; alu_* sampled on that edge.

Reset
REQ-028 reset_n=0 asynchronously forces P=P_RESET, adj_out=0, adj_valid=0, pend_valid=0; held while low.
REQ-029 A request captured before reset is discarded; first apply after release requires a new request.

Verification
REQ-030 reset_n pulsed low mid-cycle with a request pending -> P=8'h34, adj_out=0 immediately; no apply after release.
REQ-031 BCD add 45+38: alu_out=8'h8D, hc=1, co=0, NVZC -> adj_out=8'h83, C=0; 58+46: alu_out=8'hAE, hc=1, co=1 -> adj_out=8'h04, C=1.
REQ-032 BCD sub 42-15: alu_out=8'h2D, hc=0, co=1, op_sub=1 -> adj_out=8'h27, C=1.
REQ-033 Pending NZC with alu_co=1, alu_n=1, same edge as CLC -> C=0, N=1; Z per alu_z.
REQ-034 p_load with p_din=8'h00 on the same edge as a pending NVZC apply -> P=8'h30, adj_valid=1.
REQ-035 RDY low 3 cycles between capture and apply; BIT with mem_b76=2'b10, alu_z=1 -> on first RDY edge N=1, V=0, Z=1, C unchanged.
